// File: rtl/calc_engine_bcd_pkg.sv
// Shared key codes, state/op encodings and constant helpers for the BCD keypad calculator.
package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_EQ    = 4'd12;
  localparam logic [3:0] KEY_CLEAR = 4'd13;
  localparam logic [3:0] KEY_BREAK = 4'd14;
  localparam logic [3:0] KEY_MUL   = 4'd15;

  localparam logic [3:0] DASH = 4'hA;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_ENTRY_B = 3'd1,
    ST_CALC    = 3'd2,
    ST_CONVERT = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2,
    OP_MUL  = 2'd3
  } op_e;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Smallest width w with 2**w >= n.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/calc_engine_bcd_bin2bcd.sv
// Sequential double-dabble: loads a magnitude on start_i, shifts one bit per cycle for OPW cycles.
module bin2bcd_seq import calc_pkg::*; #(
  parameter int DIGITS = 4,
  parameter int OPW    = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [OPW-1:0]        bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  done_o
);

  logic [OPW-1:0]      bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [4:0]          cnt_q;
  logic                active_q;

  // bcd_o is the post-step value, so in the done_o cycle it already holds the final digits.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_o  = {adj[4*DIGITS-2:0], bin_q[OPW-1]};
    done_o = active_q && (cnt_q == 5'(OPW-1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      bin_q    <= bin_i;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      bin_q <= bin_q << 1;
      bcd_q <= bcd_o;
      cnt_q <= cnt_q + 5'd1;
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_engine_bcd.sv
// Keypad calculator core: N-digit signed add/sub/mul with left-to-right chaining and BCD display output.
module calc_engine_bcd import calc_pkg::*; #(
  parameter int DIGITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                key_valid_i,
  input  logic [3:0]          key_code_i,
  output logic [4*DIGITS-1:0] digits_o,
  output logic                neg_o,
  output logic                ovf_o,
  output logic                busy_o,
  output logic                result_valid_o
);

  localparam int OPW  = clog2(pow10(DIGITS));
  localparam int MAXV = pow10(DIGITS) - 1;
  localparam int RW   = 2*OPW + 2;
  localparam int DW   = 4*DIGITS;

  state_e              state_q, state_d;
  op_e                 op_q, op_d, nextOp_q, nextOp_d, keyOp;
  logic                showAfter_q, showAfter_d;
  logic signed [OPW:0] a_q, a_d;
  logic [OPW-1:0]      b_q, b_d;
  logic [3:0]          digCnt_q, digCnt_d;
  logic [DW-1:0]       digits_q, digits_d;
  logic                neg_q, neg_d, ovf_q, ovf_d, rv_q, rv_d, brk_q, brk_d;
  logic                negPend_q, negPend_d;
  logic [4:0]          calcCnt_q, calcCnt_d;
  logic [2*OPW-1:0]    mulAcc_q, mulAcc_d, mulCand_q, mulCand_d, mulProd;
  logic [OPW-1:0]      mulPlier_q, mulPlier_d;
  logic                mulNeg_q, mulNeg_d;

  logic                busy, isDigit, isOp, mulLast, calcDone, overflow, convStart, convDone, startCalc;
  logic [OPW:0]        aAbs;
  logic [OPW-1:0]      entryVal;
  logic signed [RW-1:0] aExt, bExt, prodExt, calcRes;
  logic [RW-1:0]       resAbs;
  logic [DW-1:0]       convBcd;

  bin2bcd_seq #(.DIGITS(DIGITS), .OPW(OPW)) u_bin2bcd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (convStart),
    .bin_i   (resAbs[OPW-1:0]),
    .bcd_o   (convBcd),
    .done_o  (convDone)
  );

  // Arithmetic datapath: the result is sized so no product or difference of two operands truncates.
  always_comb begin
    busy     = (state_q == ST_CALC) || (state_q == ST_CONVERT);
    isDigit  = key_code_i <= 4'd9;
    isOp     = (key_code_i == KEY_PLUS) || (key_code_i == KEY_MINUS) || (key_code_i == KEY_MUL);
    keyOp    = (key_code_i == KEY_MUL) ? OP_MUL : (key_code_i == KEY_MINUS) ? OP_SUB : OP_ADD;
    aAbs     = a_q[OPW] ? (OPW+1)'(-a_q) : a_q;
    entryVal = ((state_q == ST_ENTRY_A) ? a_q[OPW-1:0] : b_q) * OPW'(10) + OPW'(key_code_i);
    aExt     = {{(RW-OPW-1){a_q[OPW]}}, a_q};
    bExt     = {{(RW-OPW){1'b0}}, b_q};
    mulLast  = calcCnt_q == 5'(OPW-1);
    mulProd  = mulAcc_q + (mulPlier_q[0] ? mulCand_q : '0);
    prodExt  = {2'b00, mulProd};
    case (op_q)
      OP_ADD:  calcRes = aExt + bExt;
      OP_SUB:  calcRes = aExt - bExt;
      OP_MUL:  calcRes = mulNeg_q ? -prodExt : prodExt;
      default: calcRes = aExt;
    endcase
    resAbs    = calcRes[RW-1] ? RW'(-calcRes) : calcRes;
    overflow  = resAbs > RW'(MAXV);
    calcDone  = (state_q == ST_CALC) && ((op_q != OP_MUL) || mulLast);
    convStart = calcDone && !overflow;
  end

  // Next-state logic: CALC/CONVERT progress first, then key handling, with clear overriding everything.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    nextOp_d    = nextOp_q;
    showAfter_d = showAfter_q;
    a_d         = a_q;
    b_d         = b_q;
    digCnt_d    = digCnt_q;
    digits_d    = digits_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
    rv_d        = 1'b0;
    brk_d       = brk_q;
    negPend_d   = negPend_q;
    calcCnt_d   = calcCnt_q;
    mulAcc_d    = mulAcc_q;
    mulCand_d   = mulCand_q;
    mulPlier_d  = mulPlier_q;
    mulNeg_d    = mulNeg_q;
    startCalc   = 1'b0;

    case (state_q)
      ST_CALC: begin
        if (calcDone) begin
          if (overflow) begin
            state_d  = ST_ERROR;
            ovf_d    = 1'b1;
            neg_d    = 1'b0;
            digits_d = {DIGITS{DASH}};
          end else begin
            state_d   = ST_CONVERT;
            a_d       = calcRes[OPW:0];
            negPend_d = calcRes[RW-1];
          end
        end else begin
          mulAcc_d   = mulProd;
          mulCand_d  = mulCand_q << 1;
          mulPlier_d = mulPlier_q >> 1;
          calcCnt_d  = calcCnt_q + 5'd1;
        end
      end
      ST_CONVERT: begin
        if (convDone) begin
          digits_d = convBcd;
          neg_d    = negPend_q;
          rv_d     = 1'b1;
          if (showAfter_q) begin
            state_d = ST_SHOW;
          end else begin
            state_d  = ST_ENTRY_B;
            op_d     = nextOp_q;
            b_d      = '0;
            digCnt_d = '0;
          end
        end
      end
      default: ;
    endcase

    if (key_valid_i) begin
      if (brk_q) begin
        brk_d = 1'b0;
      end else if (key_code_i == KEY_CLEAR) begin
        state_d  = ST_ENTRY_A;
        op_d     = OP_NONE;
        a_d      = '0;
        b_d      = '0;
        digCnt_d = '0;
        digits_d = '0;
        neg_d    = 1'b0;
        ovf_d    = 1'b0;
        rv_d     = 1'b0;
      end else if (!busy && (state_q != ST_ERROR)) begin
        if (key_code_i == KEY_BREAK) begin
          brk_d = 1'b1;
        end else if (isDigit) begin
          if (state_q == ST_SHOW) begin
            state_d  = ST_ENTRY_A;
            op_d     = OP_NONE;
            a_d      = (OPW+1)'(key_code_i);
            digits_d = DW'(key_code_i);
            neg_d    = 1'b0;
            digCnt_d = 4'd1;
          end else if (digCnt_q < 4'(DIGITS)) begin
            digCnt_d = digCnt_q + 4'd1;
            digits_d = (digCnt_q == 4'd0) ? DW'(key_code_i) : ((digits_q << 4) | DW'(key_code_i));
            neg_d    = (digCnt_q == 4'd0) ? 1'b0 : neg_q;
            if (state_q == ST_ENTRY_A) a_d = {1'b0, entryVal};
            else                       b_d = entryVal;
          end
        end else if (isOp) begin
          if (state_q == ST_ENTRY_B) begin
            nextOp_d    = keyOp;
            showAfter_d = 1'b0;
            startCalc   = 1'b1;
          end else begin
            state_d  = ST_ENTRY_B;
            op_d     = keyOp;
            b_d      = '0;
            digCnt_d = '0;
            if (state_q == ST_ENTRY_A) begin
              digits_d = '0;
              neg_d    = 1'b0;
            end
          end
        end else if ((key_code_i == KEY_EQ) && (state_q == ST_ENTRY_B)) begin
          showAfter_d = 1'b1;
          startCalc   = 1'b1;
        end
      end
    end

    // Multiply works on magnitudes; the sign is reapplied at the end of CALC.
    if (startCalc) begin
      state_d    = ST_CALC;
      calcCnt_d  = '0;
      mulAcc_d   = '0;
      mulCand_d  = {{OPW{1'b0}}, aAbs[OPW-1:0]};
      mulPlier_d = b_q;
      mulNeg_d   = a_q[OPW];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_ENTRY_A;
      op_q        <= OP_NONE;
      nextOp_q    <= OP_NONE;
      showAfter_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      digCnt_q    <= '0;
      digits_q    <= '0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      rv_q        <= 1'b0;
      brk_q       <= 1'b0;
      negPend_q   <= 1'b0;
      calcCnt_q   <= '0;
      mulAcc_q    <= '0;
      mulCand_q   <= '0;
      mulPlier_q  <= '0;
      mulNeg_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      nextOp_q    <= nextOp_d;
      showAfter_q <= showAfter_d;
      a_q         <= a_d;
      b_q         <= b_d;
      digCnt_q    <= digCnt_d;
      digits_q    <= digits_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
      rv_q        <= rv_d;
      brk_q       <= brk_d;
      negPend_q   <= negPend_d;
      calcCnt_q   <= calcCnt_d;
      mulAcc_q    <= mulAcc_d;
      mulCand_q   <= mulCand_d;
      mulPlier_q  <= mulPlier_d;
      mulNeg_q    <= mulNeg_d;
    end
  end

  assign digits_o       = digits_q;
  assign neg_o          = neg_q;
  assign ovf_o          = ovf_q;
  assign busy_o         = busy;
  assign result_valid_o = rv_q;

endmodule

// File: tb/tb_calc_engine_bcd.sv
// Directed-vector bench for calc_engine_bcd with DIGITS=4 (OPW=14).
module tb_calc_engine_bcd;
  import calc_pkg::*;

  logic        clk;
  logic        rst;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic [15:0] digits;
  logic        neg, ovf, busy, resultValid;

  int nCompared;
  int nMismatched;

  calc_engine_bcd #(.DIGITS(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .key_valid_i    (keyValid),
    .key_code_i     (keyCode),
    .digits_o       (digits),
    .neg_o          (neg),
    .ovf_o          (ovf),
    .busy_o         (busy),
    .result_valid_o (resultValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle key strobe driven from a falling edge; returns on the falling edge after the accepting edge.
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    keyValid = 1'b1;
    keyCode  = c;
    @(negedge clk);
    keyValid = 1'b0;
    keyCode  = 4'd0;
  endtask

  // Counts result_valid pulses over a bounded window; lat is the falling-edge index of the first one (-1 if none).
  task automatic wait_result(input int budget, output int lat, output int pulses);
    lat    = -1;
    pulses = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (resultValid) begin
        if (pulses == 0) lat = k;
        pulses++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; keyValid = 1'b0; keyCode = 4'd0;
    #12;
    nCompared++; if (digits !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_digits got %h want 0000", digits); end
    nCompared++; if ({neg, ovf, busy, resultValid} !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_flags got %b want 0000", {neg, ovf, busy, resultValid}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    int lat, pulses;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    nCompared++; if (digits !== 16'h1234) begin nMismatched++; $display("[TB] FAIL entry_a got %h want 1234", digits); end
    press(KEY_PLUS); press(4'd5); press(4'd6); press(4'd6); press(KEY_EQ);
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL add_busy got %b want 1", busy); end
    wait_result(40, lat, pulses);
    nCompared++; if (lat !== 15) begin nMismatched++; $display("[TB] FAIL add_latency got %0d want 15", lat); end
    nCompared++; if (pulses !== 1) begin nMismatched++; $display("[TB] FAIL add_pulses got %0d want 1", pulses); end
    nCompared++; if ({neg, digits} !== {1'b0, 16'h1800}) begin nMismatched++; $display("[TB] FAIL add_result got %b/%h want 0/1800", neg, digits); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL add_idle got %b want 0", busy); end
  endtask

  task automatic test_sub_chain;
    int lat, pulses;
    press(KEY_CLEAR);
    press(4'd1); press(4'd2); press(KEY_MINUS); press(4'd3); press(4'd4); press(KEY_EQ);
    wait_result(40, lat, pulses);
    nCompared++; if ({neg, digits} !== {1'b1, 16'h0022}) begin nMismatched++; $display("[TB] FAIL sub_result got %b/%h want 1/0022", neg, digits); end
    nCompared++; if (lat !== 15) begin nMismatched++; $display("[TB] FAIL sub_latency got %0d want 15", lat); end
    press(KEY_PLUS);
    nCompared++; if ({neg, digits} !== {1'b1, 16'h0022}) begin nMismatched++; $display("[TB] FAIL chain_hold got %b/%h want 1/0022", neg, digits); end
    press(4'd5);
    nCompared++; if ({neg, digits} !== {1'b0, 16'h0005}) begin nMismatched++; $display("[TB] FAIL chain_b got %b/%h want 0/0005", neg, digits); end
    press(KEY_EQ);
    wait_result(40, lat, pulses);
    nCompared++; if ({neg, digits} !== {1'b1, 16'h0017}) begin nMismatched++; $display("[TB] FAIL chain_result got %b/%h want 1/0017", neg, digits); end
  endtask

  task automatic test_overflow;
    int lat, pulses;
    press(KEY_CLEAR);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(KEY_MUL);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(KEY_EQ);
    wait_result(40, lat, pulses);
    nCompared++; if (pulses !== 0) begin nMismatched++; $display("[TB] FAIL ovf_pulses got %0d want 0", pulses); end
    nCompared++; if ({ovf, busy, digits} !== {2'b10, 16'hAAAA}) begin nMismatched++; $display("[TB] FAIL ovf_state got %b%b/%h want 10/AAAA", ovf, busy, digits); end
    press(4'd5);
    nCompared++; if ({ovf, digits} !== {1'b1, 16'hAAAA}) begin nMismatched++; $display("[TB] FAIL ovf_ignore got %b/%h want 1/AAAA", ovf, digits); end
    press(KEY_CLEAR);
    nCompared++; if ({ovf, neg, digits} !== {2'b00, 16'h0000}) begin nMismatched++; $display("[TB] FAIL ovf_clear got %b%b/%h want 00/0000", ovf, neg, digits); end
    press(4'd7);
    nCompared++; if (digits !== 16'h0007) begin nMismatched++; $display("[TB] FAIL ovf_reentry got %h want 0007", digits); end
  endtask

  task automatic test_chain_mul;
    int lat, pulses;
    press(KEY_CLEAR);
    press(4'd5); press(KEY_PLUS); press(4'd3); press(KEY_MUL);
    wait_result(40, lat, pulses);
    nCompared++; if ({pulses, lat} !== {32'd1, 32'd15}) begin nMismatched++; $display("[TB] FAIL op_chain_pulse got %0d/%0d want 1/15", pulses, lat); end
    nCompared++; if (digits !== 16'h0008) begin nMismatched++; $display("[TB] FAIL op_chain_value got %h want 0008", digits); end
    press(4'd2);
    nCompared++; if (digits !== 16'h0002) begin nMismatched++; $display("[TB] FAIL mul_b got %h want 0002", digits); end
    press(KEY_EQ);
    wait_result(60, lat, pulses);
    nCompared++; if (lat !== 28) begin nMismatched++; $display("[TB] FAIL mul_latency got %0d want 28", lat); end
    nCompared++; if ({neg, digits} !== {1'b0, 16'h0016}) begin nMismatched++; $display("[TB] FAIL mul_result got %b/%h want 0/0016", neg, digits); end
  endtask

  task automatic test_break_busy;
    int lat, pulses;
    press(KEY_CLEAR);
    press(KEY_BREAK); press(4'd7);
    nCompared++; if (digits !== 16'h0000) begin nMismatched++; $display("[TB] FAIL break_swallow got %h want 0000", digits); end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    nCompared++; if (digits !== 16'h1234) begin nMismatched++; $display("[TB] FAIL digit_limit got %h want 1234", digits); end
    press(KEY_PLUS); press(4'd1); press(KEY_EQ);
    press(4'd5); press(KEY_MUL);
    wait_result(40, lat, pulses);
    nCompared++; if (pulses !== 1) begin nMismatched++; $display("[TB] FAIL busy_drop_pulses got %0d want 1", pulses); end
    nCompared++; if (digits !== 16'h1235) begin nMismatched++; $display("[TB] FAIL busy_drop_result got %h want 1235", digits); end
    press(4'd6);
    nCompared++; if (digits !== 16'h0006) begin nMismatched++; $display("[TB] FAIL show_digit got %h want 0006", digits); end
    press(KEY_CLEAR);
    press(4'd2); press(KEY_MUL); press(4'd3); press(KEY_EQ);
    repeat (3) @(negedge clk);
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL mul_busy got %b want 1", busy); end
    press(KEY_CLEAR);
    nCompared++; if ({busy, digits} !== {1'b0, 16'h0000}) begin nMismatched++; $display("[TB] FAIL abort got %b/%h want 0/0000", busy, digits); end
    wait_result(40, lat, pulses);
    nCompared++; if (pulses !== 0) begin nMismatched++; $display("[TB] FAIL abort_pulses got %0d want 0", pulses); end
  endtask

  task automatic test_async_reset;
    int lat, pulses;
    press(KEY_CLEAR);
    press(4'd5); press(KEY_MINUS); press(4'd9); press(KEY_EQ);
    wait_result(40, lat, pulses);
    nCompared++; if ({neg, digits} !== {1'b1, 16'h0004}) begin nMismatched++; $display("[TB] FAIL pre_reset got %b/%h want 1/0004", neg, digits); end
    press(KEY_PLUS); press(KEY_EQ);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nCompared++; if ({busy, ovf, neg, digits} !== {3'b000, 16'h0000}) begin nMismatched++; $display("[TB] FAIL async_reset got %b%b%b/%h want 000/0000", busy, ovf, neg, digits); end
    @(negedge clk);
    rst = 1'b0;
    wait_result(30, lat, pulses);
    nCompared++; if ({pulses, digits} !== {32'd0, 16'h0000}) begin nMismatched++; $display("[TB] FAIL post_reset got %0d/%h want 0/0000", pulses, digits); end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset;
    test_add;
    test_sub_chain;
    test_overflow;
    test_chain_mul;
    test_break_busy;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/calc_engine_bcd.md
Name: calc_engine_bcd

Overview:
Parametrised successor of the four-digit keypad calculator decoder. It consumes decoded key codes from the PS/2 receive path as single-cycle strobes in the system clock domain, and supports N-digit operands, add/subtract/multiply and left-to-right chaining. Signed results are converted to BCD by a sequential double-dabble converter. Its outputs feed the seven-segment multiplexer directly: BCD digits, a sign flag and an overflow flag.

Parameters:
DIGITS, 4, operand/display digit count, legal 1..8
OPW, derived (localparam) = clog2(10**DIGITS), binary operand magnitude width
MAXV, derived (localparam) = 10**DIGITS-1, largest displayable magnitude

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
key_valid_i  in  1  one-cycle strobe, key_code_i valid
key_code_i  in  4  0-9 digit, 10 '+', 11 '-', 12 '=', 13 clear, 14 break prefix, 15 '*'
digits_o  out  4*DIGITS  BCD display, digit 0 in [3:0]; 4'hA = dash
neg_o  out  1  displayed value is negative
ovf_o  out  1  error/overflow latched
busy_o  out  1  CALC or CONVERT in progress
result_valid_o  out  1  one-cycle pulse when a computed result reaches digits_o

Behaviour:
- Reset (async, any state, including mid-CALC/CONVERT): all registers 0; digits_o=0, neg_o=0, ovf_o=0, busy_o=0, result_valid_o=0; state ENTRY_A; break_pending=0.
- Break handling: accepted code 14 sets break_pending. The next accepted key only clears break_pending and has no other effect, even if it is clear.
- Keys with key_valid_i high while busy_o=1 are dropped; exception: clear (13) always aborts to ENTRY_A.
- Clear: A=B=0, op=none, display 0, neg_o=0, ovf_o=0; state ENTRY_A. Takes effect on the next edge.
- States: ENTRY_A, ENTRY_B, CALC, CONVERT, SHOW, ERROR.
- ENTRY_A / ENTRY_B digit: operand = operand*10+d and display shifts left by one digit. Ignored once DIGITS digits have been entered (a leading 0 still counts as a digit).
- ENTRY_A operator (10/11/15): latch op, B=0, display cleared; go to ENTRY_B.
- ENTRY_A '=': ignored.
- ENTRY_B operator: compute A op B (CALC, CONVERT); the result becomes signed A; latch the new op; return to ENTRY_B. The result stays displayed until B's first digit arrives.
- ENTRY_B '=': compute; go to SHOW. With no digits entered, B=0.
- SHOW digit: start a fresh ENTRY_A with that digit.
- SHOW operator: chain, using the result as A.
- SHOW '=': ignored.
- A is signed, OPW+1 bits. Result width is 2*OPW+2 bits signed, so intermediates cannot truncate.
- CALC latency: add/sub 1 cycle; multiply OPW cycles (iterative shift-add of magnitudes, sign = XOR).
- Overflow: at the end of CALC, if |result| > MAXV, go to ERROR. ERROR sets ovf_o=1 and all digits 4'hA. Only clear or reset exits ERROR; every other key is ignored.
- CONVERT: double-dabble on |result|, exactly OPW cycles. In the cycle it finishes, digits_o and neg_o update and result_valid_o pulses. A zero result always gives neg_o=0.
- Total latency from the accepting edge to the result_valid_o cycle: add/sub 1+OPW, mul 2*OPW (15 / 28 for DIGITS=4).
- busy_o is high exactly during CALC and CONVERT.

Decomposition:
- Package calc_pkg holds:
  - key code constants (KEY_PLUS=10 … KEY_MUL=15);
  - state enum;
  - op enum (OP_NONE/ADD/SUB/MUL);
  - DASH=4'hA;
  - constant functions pow10() and clog2().
- Sub-module bin2bcd_seq (params DIGITS, OPW; ports clk_i, rst_i, start_i, bin_i, bcd_o, done_o) does the iterative conversion. It is instantiated once.

Test Plan:
1. DIGITS=4; keys 1,2,3,4,+,5,6,6,= -> digits 1800, neg_o=0, single result_valid_o pulse 15 cycles after '='.
2. Keys 1,2,-,3,4,= -> digits 0022, neg_o=1. Then '+',5,= -> digits 0017, neg_o=1 (chained from -22).
3. Keys 9,9,9,9,*,9,9,9,9,= -> ovf_o=1, digits AAAA. Then 5 -> unchanged. Then 13 -> digits 0000, ovf_o=0, state ENTRY_A.
4. Keys 5,+,3,*,2,= -> after '*' display 0008 with a result_valid_o pulse; final display 0016.
5. Keys 14,7 -> display 0000. Then 1,2,3,4,5 -> display 1234. Keys strobed during busy_o are dropped. 13 during multiply -> aborts, busy_o low next cycle.
6. Assert rst_i mid-CONVERT (asynchronous, between edges) -> digits_o, busy_o, ovf_o and neg_o read 0 before the next clock edge; no result_valid_o pulse follows.
